// File: rtl/piso_arbiter_pkg.sv
// piso_pkg: shared types and constants for the piso_arbiter slice.
//   state_t            - scheduler FSM states (IDLE, STROBE, FRAME, GAP)
//   NIBBLE_W           - serializer data width
//   STROBE_CYCLES      - number of cycles ser_en is held high per frame
//   min_frame_cycles() - smallest FRAME_CYCLES the serializer tolerates
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    FRAME  = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int NIBBLE_W      = 4;
  localparam int STROBE_CYCLES = 2;

  // Start bit + 4 data bits + stop, with margin for the serializer's
  // internal sampling, needs at least this many sclk cycles.
  function automatic int min_frame_cycles();
    return 12;
  endfunction

endpackage

// File: rtl/piso_arbiter_if.sv
// piso_arbiter_if: requester-side and serializer-side bus of piso_arbiter.
//   req_valid/req_data/req_ready - per-requester nibble handshake
//   ser_data/ser_en              - registered serializer data and strobe
//   busy/grant_id                - scheduler status
//   dbg_state                    - current FSM state, for observation only
//
// Handshake: a requester raises req_valid[i] with req_data[i*DW +: DW]
// and holds both until accepted; a nibble transfers on a posedge where
// req_valid[i] && req_ready[i]. req_ready is one-hot and is only ever
// high while the scheduler is idle. Dropping req_valid before the
// transfer withdraws the request without side effects.
interface piso_arbiter_if
  import piso_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      ser_data;
  logic               ser_en;
  logic               busy;
  logic [IW-1:0]      grant_id;
  state_t             dbg_state;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_data, ser_en, busy, grant_id, dbg_state
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_data, ser_en, busy, grant_id, dbg_state
  );
endinterface

// File: rtl/piso_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   valid  - request vector
//   ptr    - index of the last winner; search starts at ptr+1 and wraps
//   onehot - one-hot winner (all zero when nothing is valid)
//   idx    - encoded winner index
//   any    - at least one request valid
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest valid
  // requester after ptr is the last (and therefore final) assignment.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = (int'(ptr) + off) % NREQ;
      if (valid[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = IW'(cand);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso_arbiter.sv
// piso_arbiter: round-robin scheduler feeding one 4-bit serializer.
//   sclk - clock, all logic on posedge
//   rst  - synchronous, active-low reset
//   bus  - piso_arbiter_if.slave (requester handshake, serializer
//          data/strobe, busy, grant_id, dbg_state)
// Each accept loads ser_data, strobes ser_en for STROBE_CYCLES cycles,
// then reserves FRAME_CYCLES + GAP_CYCLES before the next accept.
// Optional build macro PIARB_PRIO0_EN: requester 0 has strict priority
// and does not move the round-robin pointer; others rotate among
// themselves. Undefined: pure round-robin over all requesters.
module piso_arbiter
  import piso_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DW           = NIBBLE_W,
  parameter int FRAME_CYCLES = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic            sclk,
  input  logic            rst,
  piso_arbiter_if.slave   bus
);

  localparam int IW         = $clog2(NREQ);
  localparam int CMAX0      = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CMAX       = (CMAX0 > 2) ? CMAX0 : 2;
  localparam int CW         = $clog2(CMAX + 1);
  localparam int FRAME_LOAD = FRAME_CYCLES - 1;
  localparam int GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [DW-1:0]   ser_data_q;
  logic            ser_en_q;
  logic [IW-1:0]   grant_id_q;

  logic [NREQ-1:0] rr_valid;
  logic [NREQ-1:0] rr_onehot;
  logic [IW-1:0]   rr_idx;
  logic            rr_any;

  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            ptr_upd;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .valid  (rr_valid),
    .ptr    (ptr),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .any    (rr_any)
  );

`ifdef PIARB_PRIO0_EN
  // Requester 0 is removed from the rotation and overrides it.
  assign rr_valid = {bus.req_valid[NREQ-1:1], 1'b0};

  always_comb begin
    win_onehot = rr_onehot;
    win_idx    = rr_idx;
    win_any    = rr_any;
    ptr_upd    = 1'b1;
    if (bus.req_valid[0]) begin
      win_onehot = '0;
      win_onehot[0] = 1'b1;
      win_idx    = '0;
      win_any    = 1'b1;
      ptr_upd    = 1'b0;
    end
  end
`else
  assign rr_valid   = bus.req_valid;
  assign win_onehot = rr_onehot;
  assign win_idx    = rr_idx;
  assign win_any    = rr_any;
  assign ptr_upd    = 1'b1;
`endif

  assign bus.req_ready = (rst && (state == IDLE)) ? win_onehot : '0;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_en    = ser_en_q;
  assign bus.busy      = (state != IDLE);
  assign bus.grant_id  = grant_id_q;
  assign bus.dbg_state = state;

  always_ff @(posedge sclk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= IW'(NREQ - 1);
      ser_data_q <= '0;
      ser_en_q   <= 1'b0;
      grant_id_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            ser_data_q <= bus.req_data[win_idx*DW +: DW];
            grant_id_q <= win_idx;
            if (ptr_upd) ptr <= win_idx;
            cnt        <= CW'(STROBE_CYCLES - 1);
            ser_en_q   <= 1'b1;
            state      <= STROBE;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            ser_en_q <= 1'b0;
            cnt      <= CW'(FRAME_LOAD);
            state    <= FRAME;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FRAME: begin
          if (cnt == '0) begin
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              cnt   <= CW'(GAP_LOAD);
              state <= GAP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_arbiter.sv
// tb_piso_arbiter: checks piso_arbiter against a timing/rotation model.
// dut1 uses default timing (period 21); dut2 uses FRAME_CYCLES=12,
// GAP_CYCLES=0 with one continuous requester (period 15, no GAP state).
module tb_piso_arbiter;
  import piso_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int F1   = 16;
  localparam int G1   = 2;
  localparam int P1   = 3 + F1 + G1;
  localparam int F2   = 12;
  localparam int G2   = 0;
  localparam int P2   = 3 + F2 + G2;
  localparam int BIG  = 100000;
`ifdef PIARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic sclk;
  logic rst;

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  piso_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus1 ();
  piso_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus2 ();

  piso_arbiter #(.NREQ(NREQ), .DW(DW), .FRAME_CYCLES(F1), .GAP_CYCLES(G1)) dut1 (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus1)
  );

  piso_arbiter #(.NREQ(NREQ), .DW(DW), .FRAME_CYCLES(F2), .GAP_CYCLES(G2)) dut2 (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus2)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks;
  int n_errors;
  logic [DW-1:0] exp_q[$];
  int glog[$];
  int gtime[$];
  int cyc;
  int since;
  int ptr_m;
  int gid_m;
  logic [DW-1:0] data_m;
  int since2;
  logic [DW-1:0] data2_m;
  int prev2;
  int n_acc2;
  int last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Winner by the scheduling rule: nearest valid after the last grant,
  // requester 0 overriding when strict priority is built in.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (p + k) % NREQ;
      if (!(PRIO && c == 0) && v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    since  = BIG;
    ptr_m  = NREQ - 1;
    gid_m  = 0;
    data_m = '0;
    exp_q.delete();
    since2  = BIG;
    data2_m = '0;
    prev2   = -1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d);
    int w;
    bit idle;
    bit idle2;
    logic [NREQ-1:0] exp_rdy;
    logic [DW-1:0] d2;
    last_acc = -1;
    @(negedge sclk);
    d2 = DW'($urandom_range(0, 15));
    rst = r;
    bus1.req_valid = v;
    bus1.req_data  = d;
    bus2.req_valid = 4'b0001;
    bus2.req_data  = {12'h000, d2};
    #1;
    w     = pick(v, ptr_m);
    idle  = (since >= P1 - 1);
    idle2 = (since2 >= P2 - 1);
    exp_rdy = '0;
    if (r && idle && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(bus1.req_ready), 32'(exp_rdy));
    chk("ser_en", 32'(bus1.ser_en), 32'(since <= 1));
    chk("busy", 32'(bus1.busy), 32'(!idle));
    chk("ser_data", 32'(bus1.ser_data), 32'(data_m));
    chk("grant_id", 32'(bus1.grant_id), 32'(gid_m));
    chk("idle_state", 32'(bus1.dbg_state == IDLE), 32'(idle));
    if (since == 0) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
      else chk("sb_nibble", 32'(bus1.ser_data), 32'(exp_q.pop_front()));
    end
    chk("d2_ready", 32'(bus2.req_ready), 32'((r && idle2) ? 1 : 0));
    chk("d2_ser_en", 32'(bus2.ser_en), 32'(since2 <= 1));
    chk("d2_busy", 32'(bus2.busy), 32'(!idle2));
    chk("d2_ser_data", 32'(bus2.ser_data), 32'(data2_m));
    chk("d2_no_gap", 32'(bus2.dbg_state == GAP), 32'(0));
    @(posedge sclk);
    cyc++;
    if (!r) begin
      model_reset();
    end else begin
      if (idle && w >= 0) begin
        since  = 0;
        data_m = d[w*DW +: DW];
        gid_m  = w;
        if (!(PRIO && w == 0)) ptr_m = w;
        exp_q.push_back(data_m);
        glog.push_back(w);
        gtime.push_back(cyc);
        last_acc = w;
      end else if (since < BIG) begin
        since++;
      end
      if (idle2) begin
        since2  = 0;
        data2_m = d2;
        if (prev2 >= 0) chk("d2_period", 32'(cyc - prev2), 32'(P2));
        prev2 = cyc;
        n_acc2++;
      end else if (since2 < BIG) begin
        since2++;
      end
    end
  endtask

  task automatic clear_log();
    glog.delete();
    gtime.delete();
  endtask

  task automatic check_spacing(input string tag, input int n);
    for (int k = 1; k < n && k < gtime.size(); k++)
      chk(tag, 32'(gtime[k] - gtime[k-1]), 32'(P1));
  endtask

  // ---------------- stimulus ----------------
  logic [NREQ-1:0]    pend;
  logic [NREQ*DW-1:0] pdat;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    n_acc2   = 0;
    last_acc = -1;
    model_reset();
    rst = 1'b0;
    bus1.req_valid = '1;
    bus1.req_data  = 16'h4321;
    bus2.req_valid = 4'b0001;
    bus2.req_data  = '0;
    @(posedge sclk);

    // Reset held with every requester valid.
    repeat (3) step(1'b0, 4'b1111, 16'h4321);

    // Single requester 1, nibble A; second accept one period later.
    clear_log();
    repeat (P1 + 4) step(1'b1, 4'b0010, 16'h00A0);
    chk("t2_count", 32'(glog.size()), 32'(2));
    if (glog.size() >= 1) chk("t2_gid", 32'(glog[0]), 32'(1));
    check_spacing("t2_spacing", 2);

    // All four continuously valid with nibbles 1..4.
    repeat (2) step(1'b0, 4'b0000, '0);
    clear_log();
    repeat (5 * P1 - 10) step(1'b1, 4'b1111, 16'h4321);
    chk("t3_count", 32'(glog.size()), 32'(5));
    for (int k = 0; k < 5 && k < glog.size(); k++)
      chk("t3_seq", 32'(glog[k]), 32'(PRIO ? 0 : k % NREQ));
    check_spacing("t3_spacing", 5);

    // Reset eight cycles into a frame, then req0 and req2 compete.
    repeat (2) step(1'b0, 4'b0000, '0);
    clear_log();
    step(1'b1, 4'b0010, 16'h00B0);
    chk("t4_accept", 32'(glog.size()), 32'(1));
    repeat (7) step(1'b1, 4'b0000, '0);
    step(1'b0, 4'b0000, '0);
    clear_log();
    repeat (3) step(1'b1, 4'b0101, 16'h0C0D);
    chk("t4_count", 32'(glog.size()), 32'(1));
    if (glog.size() >= 1) chk("t4_first", 32'(glog[0]), 32'(0));

    // req0 and req2 continuously valid.
    repeat (2) step(1'b0, 4'b0000, '0);
    clear_log();
    repeat (4 * P1 - 10) step(1'b1, 4'b0101, 16'h0E0F);
    chk("t5_count", 32'(glog.size()), 32'(4));
    for (int k = 0; k < 4 && k < glog.size(); k++)
      chk("t5_seq", 32'(glog[k]), 32'(PRIO ? 0 : 2 * (k % 2)));

    // Randomized requesters that hold until accepted or withdraw.
    pend = '0;
    pdat = '0;
    repeat (800) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pdat[i*DW +: DW] = DW'($urandom_range(0, 15));
        end else if (pend[i] && $urandom_range(0, 39) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step(($urandom_range(0, 199) != 0), pend, pdat);
      if (last_acc >= 0) pend[last_acc] = 1'b0;
    end

    chk("d2_accepts_seen", 32'(n_acc2 >= 20), 32'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
